// File: rtl/oam_dma_if.sv
// oam_dma_if -- bus bundle between the OAM DMA controller and its neighbours.
//
// Signals:
//   cpu_addr[15:0], cpu_wren, cpu_data_in[7:0]  CPU write path (FF46 decode)
//   dma_reg[7:0]                                readback of the last FF46 write
//   dma_active                                  copy in progress (memory map gate)
//   dma_src_addr[15:0], dma_rd_en               source read request
//   dma_rd_data[7:0]                            source data, one clock after dma_rd_en
//   oam_wr_addr[7:0], oam_wr_data[7:0], oam_wren  OAM write port
//
// Modports:
//   master -- the system side (CPU, memory map, source RAM)
//   slave  -- the DMA controller itself
interface oam_dma_if;
  logic [15:0] cpu_addr;
  logic        cpu_wren;
  logic [7:0]  cpu_data_in;
  logic [7:0]  dma_reg;
  logic        dma_active;
  logic [15:0] dma_src_addr;
  logic        dma_rd_en;
  logic [7:0]  dma_rd_data;
  logic [7:0]  oam_wr_addr;
  logic [7:0]  oam_wr_data;
  logic        oam_wren;

  modport master (
    output cpu_addr, cpu_wren, cpu_data_in, dma_rd_data,
    input  dma_reg, dma_active, dma_src_addr, dma_rd_en,
           oam_wr_addr, oam_wr_data, oam_wren
  );

  modport slave (
    input  cpu_addr, cpu_wren, cpu_data_in, dma_rd_data,
    output dma_reg, dma_active, dma_src_addr, dma_rd_en,
           oam_wr_addr, oam_wr_data, oam_wren
  );
endinterface

// File: rtl/oam_dma.sv
// oam_dma -- DMG OAM DMA controller behind register FF46.
//
// A CPU write to FF46 latches the value, waits START_DELAY clocks, then copies
// NUM_BYTES bytes from {page,8'h00} into OAM offsets 0..NUM_BYTES-1, one byte
// every BYTE_CYCLES clocks. Pages E0-FF are folded onto C0-DF (echo RAM).
//
// Ports:
//   clock  system clock
//   reset  synchronous active-high reset; aborts any transfer
//   bus    oam_dma_if.slave (CPU write path, source read port, OAM write port,
//          dma_reg readback and dma_active)
module oam_dma #(
  parameter int BYTE_CYCLES = 4,   // clocks per byte, >= 2
  parameter int START_DELAY = 4,   // clocks from trigger to first read, >= 1
  parameter int NUM_BYTES   = 160  // bytes per transfer, 1..256
) (
  input  logic     clock,
  input  logic     reset,
  oam_dma_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;

  localparam int CYC_W = (BYTE_CYCLES > 2) ? $clog2(BYTE_CYCLES) : 1;
  localparam int DLY_W = (START_DELAY > 2) ? $clog2(START_DELAY) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BYTE_CYCLES - 1);
  localparam logic [CYC_W-1:0] CYC_WR   = CYC_W'(1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(START_DELAY - 1);
  localparam logic [7:0]       IDX_LAST = 8'(NUM_BYTES - 1);

  // control state
  logic [1:0]       state_reg, state_next;
  logic [DLY_W-1:0] dly_reg, dly_next;
  logic [CYC_W-1:0] cyc_reg, cyc_next;
  logic [7:0]       idx_reg, idx_next;
  logic [7:0]       page_reg, page_next;
  logic [7:0]       ff46_reg, ff46_next;

  // output registers
  logic             active_reg;
  logic             rd_en_reg;
  logic [15:0]      src_addr_reg;
  logic             wren_reg;
  logic [7:0]       oam_addr_reg;
  logic [7:0]       wr_data_hold_reg;

  logic             trigger;
  logic             rd_fire_next;
  logic             wr_fire_next;

  assign trigger = bus.cpu_wren && (bus.cpu_addr == 16'hFF46);

  always_comb begin
    state_next = state_reg;
    dly_next   = dly_reg;
    cyc_next   = cyc_reg;
    idx_next   = idx_reg;
    page_next  = page_reg;
    ff46_next  = ff46_reg;

    case (state_reg)
      ST_START: begin
        if (dly_reg == DLY_LAST) begin
          state_next = ST_XFER;
          idx_next   = 8'h00;
          cyc_next   = '0;
        end else begin
          dly_next = dly_reg + 1'b1;
        end
      end
      ST_XFER: begin
        if (cyc_reg == CYC_LAST) begin
          cyc_next = '0;
          if (idx_reg == IDX_LAST) begin
            state_next = ST_IDLE;
          end else begin
            idx_next = idx_reg + 8'h01;
          end
        end else begin
          cyc_next = cyc_reg + 1'b1;
        end
      end
      default: ;
    endcase

    // A new FF46 write overrides whatever the sequencer wanted, including the
    // final clock of a transfer, so back-to-back copies never see IDLE.
    if (trigger) begin
      ff46_next  = bus.cpu_data_in;
      page_next  = (bus.cpu_data_in >= 8'hE0) ? (bus.cpu_data_in - 8'h20)
                                              : bus.cpu_data_in;
      state_next = ST_START;
      dly_next   = '0;
      idx_next   = 8'h00;
      cyc_next   = '0;
    end
  end

  // Strobes are registered from the next-state decode, so each one is high
  // exactly while the FSM sits in the matching state.
  assign rd_fire_next = (state_next == ST_XFER) && (cyc_next == '0);
  assign wr_fire_next = (state_next == ST_XFER) && (cyc_next == CYC_WR);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      dly_reg          <= '0;
      cyc_reg          <= '0;
      idx_reg          <= 8'h00;
      page_reg         <= 8'h00;
      ff46_reg         <= 8'h00;
      active_reg       <= 1'b0;
      rd_en_reg        <= 1'b0;
      src_addr_reg     <= 16'h0000;
      wren_reg         <= 1'b0;
      oam_addr_reg     <= 8'h00;
      wr_data_hold_reg <= 8'h00;
    end else begin
      state_reg  <= state_next;
      dly_reg    <= dly_next;
      cyc_reg    <= cyc_next;
      idx_reg    <= idx_next;
      page_reg   <= page_next;
      ff46_reg   <= ff46_next;
      active_reg <= (state_next != ST_IDLE);
      rd_en_reg  <= rd_fire_next;
      wren_reg   <= wr_fire_next;
      if (rd_fire_next) begin
        src_addr_reg <= {page_next, idx_next};
      end
      if (wr_fire_next) begin
        oam_addr_reg <= idx_next;
      end
      // Keep the last written byte visible on oam_wr_data between writes.
      if (wren_reg) begin
        wr_data_hold_reg <= bus.dma_rd_data;
      end
    end
  end

  assign bus.dma_reg      = ff46_reg;
  assign bus.dma_active   = active_reg;
  assign bus.dma_rd_en    = rd_en_reg;
  assign bus.dma_src_addr = src_addr_reg;
  assign bus.oam_wren     = wren_reg;
  assign bus.oam_wr_addr  = oam_addr_reg;
  // Source RAM output only becomes valid in the write clock, so the write data
  // is passed straight through while the strobe is high.
  assign bus.oam_wr_data  = wren_reg ? bus.dma_rd_data : wr_data_hold_reg;

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma -- directed self-checking bench for oam_dma.
// Source memory model returns addr[7:0]^8'h5A one clock after dma_rd_en.
module tb_oam_dma;

  logic clk;
  logic srst;
  int   tests;
  int   failed;
  int   cycle_cnt;
  int   trig_cycle;

  oam_dma_if bus ();

  oam_dma #(
    .BYTE_CYCLES(4),
    .START_DELAY(4),
    .NUM_BYTES  (160)
  ) dut (
    .clock(clk),
    .reset(srst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // synchronous source RAM model
  always @(posedge clk) begin
    if (bus.dma_rd_en) bus.dma_rd_data <= bus.dma_src_addr[7:0] ^ 8'h5A;
  end

  // event logs filled by the monitor
  logic [15:0] rd_q[$];
  int          rd_cyc_q[$];
  logic [7:0]  wr_addr_q[$];
  int          act_cnt;
  int          first_act;
  int          last_act;
  int          last_rd_cyc;
  int          data_err;
  int          lat_err;

  always @(negedge clk) begin
    if (bus.dma_active) begin
      if (act_cnt == 0) first_act = cycle_cnt;
      last_act = cycle_cnt;
      act_cnt++;
    end
    if (bus.dma_rd_en) begin
      rd_q.push_back(bus.dma_src_addr);
      rd_cyc_q.push_back(cycle_cnt);
      last_rd_cyc = cycle_cnt;
    end
    if (bus.oam_wren) begin
      wr_addr_q.push_back(bus.oam_wr_addr);
      if (bus.oam_wr_data !== (bus.oam_wr_addr ^ 8'h5A)) data_err++;
      if (cycle_cnt != last_rd_cyc + 1) lat_err++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    rd_q.delete();
    rd_cyc_q.delete();
    wr_addr_q.delete();
    act_cnt     = 0;
    first_act   = 0;
    last_act    = 0;
    last_rd_cyc = -10;
    data_err    = 0;
    lat_err     = 0;
  endtask

  // Drives one CPU bus cycle; call just after a negedge.
  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic we);
    bus.cpu_addr    = a;
    bus.cpu_data_in = d;
    bus.cpu_wren    = we;
    @(posedge clk);
    #1;
    trig_cycle   = cycle_cnt;
    bus.cpu_wren = 1'b0;
    $display("[TB] cpu %s addr=%04h data=%02h at cycle %0d", we ? "wr" : "rd", a, d, trig_cycle);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (bus.dma_active && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, bus.dma_active}, 32'd0);
  endtask

  // bounded wait for a write to a given OAM offset, leaves the bench at that negedge
  task automatic wait_wr(input string tag, input logic [7:0] off);
    int n = 0;
    @(negedge clk);
    while (!(bus.oam_wren && bus.oam_wr_addr == off) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, bus.oam_wren}, 32'd1);
  endtask

  task automatic check_seq(input string tag, input int skip);
    int errs = 0;
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      if (i < skip) begin
        if (wr_addr_q[i] != 8'(i)) errs++;
      end else if (wr_addr_q[i] != 8'(i - skip)) begin
        errs++;
      end
    end
    check(tag, errs, 0);
  endtask

  initial begin
    int wr_at_reset;
    tests           = 0;
    failed          = 0;
    cycle_cnt       = 0;
    trig_cycle      = 0;
    bus.cpu_addr    = 16'h0000;
    bus.cpu_wren    = 1'b0;
    bus.cpu_data_in = 8'h00;
    bus.dma_rd_data = 8'h00;
    clear_logs();

    // ---------------- reset state
    srst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dma_reg", bus.dma_reg, 8'h00);
    check("rst_active", bus.dma_active, 1'b0);
    check("rst_rd_en", bus.dma_rd_en, 1'b0);
    check("rst_wren", bus.oam_wren, 1'b0);
    check("rst_src", bus.dma_src_addr, 16'h0000);
    srst = 1'b0;

    // ---------------- basic copy from C100
    @(negedge clk);
    clear_logs();
    cpu_cycle(16'hFF46, 8'hC1, 1'b1);
    check("basic_active_rise", bus.dma_active, 1'b1);
    wait_idle("basic_done", 2000);
    check("basic_active_len", act_cnt, 644);
    check("basic_no_gap", last_act - first_act + 1, act_cnt);
    check("basic_first_rd_dly", rd_cyc_q.size() > 0 ? rd_cyc_q[0] - trig_cycle : -1, 4);
    check("basic_first_src", rd_q.size() > 0 ? rd_q[0] : 16'hxxxx, 16'hC100);
    check("basic_nwr", wr_addr_q.size(), 160);
    check("basic_last_off", wr_addr_q.size() > 0 ? wr_addr_q[$] : 8'hxx, 8'h9F);
    check("basic_data", data_err, 0);
    check("basic_latency", lat_err, 0);
    check_seq("basic_seq", 160);
    check("basic_dma_reg", bus.dma_reg, 8'hC1);

    // ---------------- echo remap F2 -> D2
    @(negedge clk);
    clear_logs();
    cpu_cycle(16'hFF46, 8'hF2, 1'b1);
    wait_idle("echo_done", 2000);
    check("echo_first_src", rd_q.size() > 0 ? rd_q[0] : 16'hxxxx, 16'hD200);
    check("echo_last_src", rd_q.size() > 0 ? rd_q[$] : 16'hxxxx, 16'hD29F);
    check("echo_nwr", wr_addr_q.size(), 160);
    check("echo_dma_reg", bus.dma_reg, 8'hF2);

    // ---------------- restart during byte 10 write clock
    @(negedge clk);
    clear_logs();
    cpu_cycle(16'hFF46, 8'hC1, 1'b1);
    wait_wr("rs_reach_b10", 8'h0A);
    cpu_cycle(16'hFF46, 8'hC3, 1'b1);
    wait_idle("rs_done", 2000);
    check("rs_nwr", wr_addr_q.size(), 171);
    check("rs_nrd", rd_q.size(), 171);
    check("rs_b10_off", wr_addr_q.size() > 10 ? wr_addr_q[10] : 8'hxx, 8'h0A);
    check("rs_new_src", rd_q.size() > 11 ? rd_q[11] : 16'hxxxx, 16'hC300);
    check("rs_new_dly", rd_cyc_q.size() > 11 ? rd_cyc_q[11] - trig_cycle : -1, 4);
    check("rs_active_len", act_cnt, 690);
    check("rs_no_gap", last_act - first_act + 1, act_cnt);
    check("rs_data", data_err, 0);
    check_seq("rs_seq", 11);
    check("rs_dma_reg", bus.dma_reg, 8'hC3);

    // ---------------- reset during byte 50 read clock
    @(negedge clk);
    clear_logs();
    cpu_cycle(16'hFF46, 8'hC1, 1'b1);
    begin
      int n = 0;
      while (!(bus.dma_rd_en && bus.dma_src_addr[7:0] == 8'h32) && n < 1000) begin
        @(negedge clk);
        n++;
      end
    end
    check("mr_reach_b50", bus.dma_src_addr, 16'hC132);
    srst = 1'b1;
    @(posedge clk);
    #1;
    check("mr_active", bus.dma_active, 1'b0);
    check("mr_rd_en", bus.dma_rd_en, 1'b0);
    check("mr_wren", bus.oam_wren, 1'b0);
    check("mr_src", bus.dma_src_addr, 16'h0000);
    check("mr_wr_addr", bus.oam_wr_addr, 8'h00);
    check("mr_wr_data", bus.oam_wr_data, 8'h00);
    check("mr_dma_reg", bus.dma_reg, 8'h00);
    srst = 1'b0;
    wr_at_reset = wr_addr_q.size();
    check("mr_nwr_before", wr_at_reset, 50);
    repeat (700) @(negedge clk);
    check("mr_nwr_after", wr_addr_q.size(), wr_at_reset);

    // ---------------- address decode: other address, and a read of FF46
    @(negedge clk);
    clear_logs();
    cpu_cycle(16'hFF45, 8'hC1, 1'b1);
    @(negedge clk);
    cpu_cycle(16'hFF46, 8'h77, 1'b0);
    repeat (20) @(negedge clk);
    check("dec_active", act_cnt, 0);
    check("dec_nrd", rd_q.size(), 0);
    check("dec_dma_reg", bus.dma_reg, 8'h00);

    // ---------------- back-to-back: retrigger on the final XFER clock
    @(negedge clk);
    clear_logs();
    cpu_cycle(16'hFF46, 8'hC1, 1'b1);
    wait_wr("b2b_reach_last", 8'h9F);
    @(negedge clk);
    @(negedge clk);
    cpu_cycle(16'hFF46, 8'hC3, 1'b1);
    check("b2b_active_held", bus.dma_active, 1'b1);
    wait_idle("b2b_done", 2000);
    check("b2b_nwr", wr_addr_q.size(), 320);
    check("b2b_active_len", act_cnt, 1288);
    check("b2b_no_gap", last_act - first_act + 1, act_cnt);
    check("b2b_second_src", rd_q.size() > 160 ? rd_q[160] : 16'hxxxx, 16'hC300);
    check("b2b_second_dly", rd_cyc_q.size() > 160 ? rd_cyc_q[160] - trig_cycle : -1, 4);
    check("b2b_last_off", wr_addr_q.size() > 0 ? wr_addr_q[$] : 8'hxx, 8'h9F);
    check("b2b_data", data_err, 0);
    check_seq("b2b_seq", 160);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
OAM DMA controller behind the DMG register FF46. A CPU write to FF46 starts a copy of NUM_BYTES bytes from source page {value,8'h00} into OAM offsets 0x00..NUM_BYTES-1. It drives a read port on the system memory map and a dedicated OAM write port. dma_active tells the memory map to block CPU accesses outside HRAM for the duration of the copy.

Parameters:
BYTE_CYCLES, 4, clocks per transferred byte (one M-cycle); must be >= 2
START_DELAY, 4, clocks between the FF46 write and the first source read
NUM_BYTES, 160, bytes copied per transfer

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_addr  in  16  CPU bus address
cpu_wren  in  1  CPU write strobe
cpu_data_in  in  8  CPU write data
dma_reg  out  8  last value written to FF46 (CPU readback)
dma_active  out  1  transfer in progress; memory map blocks CPU except FF80-FFFE
dma_src_addr  out  16  source read address
dma_rd_en  out  1  source read request, one clock per byte
dma_rd_data  in  8  source data, valid the clock after dma_rd_en (synchronous RAM)
oam_wr_addr  out  8  OAM write offset
oam_wr_data  out  8  OAM write data
oam_wren  out  1  OAM write strobe

Behaviour:
- Reset (synchronous, active-high; dominates everything):
  - state=IDLE; dma_reg=8'h00; counters=0
  - dma_active, dma_rd_en and oam_wren = 0; dma_src_addr, oam_wr_addr and oam_wr_data = 0
  - a transfer in flight is aborted; no further OAM writes.
- Trigger: cpu_wren=1 && cpu_addr==16'hFF46 at a rising edge.
  - That edge: dma_reg<=cpu_data_in, page<=remapped value, state<=START, dly<=0.
  - Writes to any other address are ignored.
- Page remap: value>=8'hE0 uses value-8'h20 (echo RAM, e.g. F2->D2); otherwise value unchanged.
- States:
  - IDLE: all strobes 0, dma_active=0.
  - START: dma_active=1, no strobes. Lasts START_DELAY clocks (dly counts 0..START_DELAY-1), then XFER with idx=0, cyc=0.
  - XFER: dma_active=1. cyc counts 0..BYTE_CYCLES-1 and wraps, incrementing idx.
    - cyc==0: dma_rd_en=1, dma_src_addr={page, idx[7:0]}.
    - cyc==1: oam_wren=1, oam_wr_addr=idx, oam_wr_data=dma_rd_data.
    - other cyc values: no strobes.
    - At idx==NUM_BYTES-1 and cyc==BYTE_CYCLES-1: next state IDLE.
- All outputs are registered-state decodes (Moore). dma_src_addr and oam_wr_addr hold their last values when strobes are low.
- Timing: dma_active is high for exactly START_DELAY + NUM_BYTES*BYTE_CYCLES clocks (644 at defaults). The first dma_rd_en comes START_DELAY clocks after the trigger edge. Each OAM write comes 1 clock after its read.
- Restart: a trigger while in START or XFER reloads dma_reg/page and goes to START with idx=0.
  - The current cycle's outputs still come from the old state, so a cyc==1 write in that cycle completes.
  - No later bytes of the old transfer are read or written.
  - dma_active stays high with no gap.
- Trigger on the clock XFER would return to IDLE: the restart wins, next state is START.
- idx is 8 bits and never exceeds NUM_BYTES-1. oam_wr_addr never exceeds 8'h9F at defaults.

Test Plan:
- Basic copy: reset, then write FF46=8'hC1 with source model C100+i -> data i^8'h5A.
  - dma_active rises on the edge after the write and stays high 644 clocks.
  - First dma_rd_en at 4 clocks with dma_src_addr=16'hC100.
  - 160 oam_wren pulses, offset i carrying i^8'h5A; last offset 8'h9F.
  - dma_reg=8'hC1.
- Echo remap: write FF46=8'hF2 -> first dma_src_addr=16'hD200, last 16'hD29F; dma_reg reads 8'hF2.
- Restart: write 8'hC1, then 8'hC3 during byte 10's cyc==1.
  - Byte 10 is still written to offset 8'h0A.
  - After 4 START clocks, reads restart at 16'hC300.
  - 160 further writes from offset 0; dma_active never drops.
- Reset mid-transfer: assert reset during byte 50 -> next clock all outputs are 0 and dma_reg=0; no further oam_wren.
- Decode check: write FF45=8'hC1 and read (cpu_wren=0) FF46 -> no transfer, dma_active stays 0, dma_reg unchanged.
- Back-to-back: second trigger on the final XFER clock -> no idle gap; second transfer completes with 160 writes.
